// File: rtl/alu_arbiter_if.sv
// Bundle between the ALU arbiter, its requesters, the shared ALU and the response consumer.
//  req/req_op1/req_op2/req_op : requester levels and packed per-requester operands
//  gnt                        : one-hot grant pulse back to requesters
//  alu_operand1/2, alu_op     : registered drive to the shared ALU
//  alu_result, alu_zero       : combinational return from the ALU
//  rsp_valid/rsp_ready        : response handshake; rsp_id/result/zero/err are its payload
//  busy                       : arbiter is not idle
// slave = arbiter side, master = environment side (requesters, ALU, consumer).
interface alu_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 3,
  parameter int unsigned IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_op1;
  logic [NREQ*WIDTH-1:0] req_op2;
  logic [NREQ*OPW-1:0]   req_op;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      alu_operand1;
  logic [WIDTH-1:0]      alu_operand2;
  logic [OPW-1:0]        alu_op;
  logic [WIDTH-1:0]      alu_result;
  logic                  alu_zero;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_zero;
  logic                  rsp_err;
  logic                  busy;

  modport slave (
    input  req, req_op1, req_op2, req_op, alu_result, alu_zero, rsp_ready,
    output gnt, alu_operand1, alu_operand2, alu_op,
           rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
  );

  modport master (
    output req, req_op1, req_op2, req_op, alu_result, alu_zero, rsp_ready,
    input  gnt, alu_operand1, alu_operand2, alu_op,
           rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// One operation at a time: IDLE (grant + latch operands) -> EXEC (ALU settles,
// result captured) -> RESP (valid/ready handshake tagged with requester id).
// Ports:
//  clk    : rising-edge clock
//  rst_n  : asynchronous active-low reset; discards any in-flight operation
//  bus    : alu_arbiter_if slave modport (requests, grant, ALU drive/return, response)
module alu_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 3,
  parameter int unsigned IDW   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  // First op code the ALU does not implement (ADD/SUB/AND/OR occupy 0..3).
  localparam int unsigned FIRST_BAD_OP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   pick_idx;
  logic             pick_valid;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;
  logic             rsp_err_q;
  logic             load_en;
  logic             capture_en;
  logic             release_en;
  logic             op_bad;
  logic [NREQ-1:0]  gnt_c;

  logic [WIDTH-1:0] op1_arr [NREQ];
  logic [WIDTH-1:0] op2_arr [NREQ];
  logic [OPW-1:0]   op_arr  [NREQ];

  // Index a + k modulo NREQ; a < NREQ and k <= NREQ, so one subtraction suffices.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int unsigned k);
    int unsigned s;
    s = 32'(a) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Unpack the flat per-requester operand buses.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op1_arr[i] = bus.req_op1[i*WIDTH +: WIDTH];
    assign op2_arr[i] = bus.req_op2[i*WIDTH +: WIDTH];
    assign op_arr[i]  = bus.req_op[i*OPW +: OPW];
  end

  // Round-robin pick: first active request scanning upward from ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!pick_valid && bus.req[wrap_add(ptr_q, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // Grant is a same-cycle pulse; held low while reset is asserted.
  always_comb begin
    gnt_c = '0;
    if (rst_n && (state_q == IDLE) && pick_valid) gnt_c[pick_idx] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath enables.
  always_comb begin
    state_d    = state_q;
    load_en    = 1'b0;
    capture_en = 1'b0;
    release_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          load_en = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture_en = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          release_en = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched request: drives the ALU for the whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q <= '0;
      op2_q <= '0;
      op_q  <= '0;
      id_q  <= '0;
    end else if (load_en) begin
      op1_q <= op1_arr[pick_idx];
      op2_q <= op2_arr[pick_idx];
      op_q  <= op_arr[pick_idx];
      id_q  <= pick_idx;
    end
  end

  assign op_bad = (32'(op_q) >= FIRST_BAD_OP);

  // Response capture; unsupported ops never look at the (undefined) ALU output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else if (capture_en) begin
      if (op_bad) begin
        rsp_result_q <= '0;
        rsp_zero_q   <= 1'b1;
        rsp_err_q    <= 1'b1;
      end else begin
        rsp_result_q <= bus.alu_result;
        rsp_zero_q   <= bus.alu_zero;
        rsp_err_q    <= 1'b0;
      end
    end
  end

  // Pointer moves past the served requester only once its response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ptr_q <= '0;
    else if (release_en) ptr_q <= wrap_add(id_q, 1);
  end

  assign bus.gnt          = gnt_c;
  assign bus.alu_operand1 = op1_q;
  assign bus.alu_operand2 = op2_q;
  assign bus.alu_op       = op_q;
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_id       = id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table vectors, directed multi-cycle
// sequences (backpressure, round-robin order, withdrawal, reset mid-op) and
// randomized traffic against a queue-free arithmetic reference model.
module tb_alu_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int OPW   = 3;
  localparam int IDW   = 2;

  logic clk;
  logic rst_n;

  alu_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW), .IDW(IDW)) bus ();

  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: undefined ops return garbage so the arbiter must ignore it.
  logic [7:0] junk = 8'h00;
  logic [7:0] alu_res;
  always @(negedge clk) junk <= 8'($urandom);
  always_comb begin
    alu_res = junk;
    case (bus.alu_op)
      3'd0: alu_res = bus.alu_operand1 + bus.alu_operand2;
      3'd1: alu_res = bus.alu_operand1 - bus.alu_operand2;
      3'd2: alu_res = bus.alu_operand1 & bus.alu_operand2;
      3'd3: alu_res = bus.alu_operand1 | bus.alu_operand2;
      default: alu_res = junk;
    endcase
    bus.alu_result = alu_res;
    bus.alu_zero   = (bus.alu_op < 3'd4) ? (alu_res == 8'h00) : junk[0];
  end

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;

  logic [7:0] t_op1 [NREQ];
  logic [7:0] t_op2 [NREQ];
  logic [2:0] t_op  [NREQ];

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    int         stall;
    logic [7:0] res;
    logic       zero;
    logic       err;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected response from the op definitions, in plain integer arithmetic.
  function automatic void ref_alu(input int a, input int b, input int op,
                                  output logic [7:0] r, output logic z, output logic e);
    int v;
    e = 1'b0;
    case (op)
      0: v = (a + b) % 256;
      1: v = (a - b + 256) % 256;
      2: v = a & b;
      3: v = a | b;
      default: begin v = 0; e = 1'b1; end
    endcase
    r = 8'(v);
    z = (v == 0);
  endfunction

  // Next requester served: nearest set bit at or after the pointer, circularly.
  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op1[i*WIDTH +: WIDTH] = t_op1[i];
      bus.req_op2[i*WIDTH +: WIDTH] = t_op2[i];
      bus.req_op[i*OPW +: OPW]      = t_op[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arbitration round from IDLE; called 1 time unit after a rising edge.
  task automatic run_op(input logic [3:0] mask, input bit hold, input int stall,
                        output int got_id, output logic [7:0] g_res,
                        output logic g_zero, output logic g_err);
    int         exp_id;
    logic [7:0] er;
    logic       ez, ee;
    logic [3:0] g;
    got_id = -1; g_res = '0; g_zero = 1'b0; g_err = 1'b0;
    drive_ops();
    bus.req = mask;
    #1;
    exp_id = rr_pick(mask, m_ptr);
    g = bus.gnt;
    for (int i = 0; i < NREQ; i++) if (g[i]) got_id = i;
    chk("gnt", 32'(g), (exp_id < 0) ? 32'd0 : (32'd1 << exp_id));
    tick();
    if (exp_id < 0) begin
      chk("idle_busy", 32'(bus.busy), 32'd0);
      return;
    end
    if (!hold) bus.req = '0;
    ref_alu(int'(t_op1[exp_id]), int'(t_op2[exp_id]), int'(t_op[exp_id]), er, ez, ee);
    chk("exec_busy", 32'(bus.busy), 32'd1);
    chk("exec_gnt", 32'(bus.gnt), 32'd0);
    chk("exec_valid", 32'(bus.rsp_valid), 32'd0);
    chk("alu_drive", {bus.alu_operand1, bus.alu_operand2, bus.alu_op},
        {t_op1[exp_id], t_op2[exp_id], t_op[exp_id]});
    tick();
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
    chk("rsp_fields", {bus.rsp_result, bus.rsp_zero, bus.rsp_err}, {er, ez, ee});
    chk("resp_gnt", 32'(bus.gnt), 32'd0);
    g_res = bus.rsp_result; g_zero = bus.rsp_zero; g_err = bus.rsp_err;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_err},
          {2'(exp_id), er, ez, ee});
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("post_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
    m_ptr = (exp_id + 1) % NREQ;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_a"}, {bus.gnt, bus.alu_operand1, bus.alu_operand2, bus.alu_op}, 32'd0);
    chk({name, "_b"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_zero,
                       bus.rsp_err, bus.busy}, 32'd0);
  endtask

  initial begin
    int         gid;
    logic [7:0] r;
    logic       z, e;
    logic [3:0] ord_mask [8];
    int         ord_id   [8];

    tbl[0] = '{0, 8'h05, 8'h03, 3'd0, 0, 8'h08, 1'b0, 1'b0};
    tbl[1] = '{0, 8'h10, 8'h10, 3'd1, 5, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{1, 8'hFF, 8'h01, 3'd0, 0, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{2, 8'h12, 8'h34, 3'd5, 0, 8'h00, 1'b1, 1'b1};
    tbl[4] = '{3, 8'h03, 8'h05, 3'd1, 1, 8'hFE, 1'b0, 1'b0};
    tbl[5] = '{1, 8'hF0, 8'h3C, 3'd2, 0, 8'h30, 1'b0, 1'b0};
    tbl[6] = '{2, 8'hF0, 8'h0C, 3'd3, 2, 8'hFC, 1'b0, 1'b0};
    tbl[7] = '{3, 8'hAA, 8'h55, 3'd2, 0, 8'h00, 1'b1, 1'b0};
    tbl[8] = '{0, 8'h7F, 8'h01, 3'd0, 0, 8'h80, 1'b0, 1'b0};
    tbl[9] = '{3, 8'h01, 8'h02, 3'd7, 0, 8'h00, 1'b1, 1'b1};

    ord_mask = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hB};
    ord_id   = '{0, 1, 2, 3, 0, 1, 2, 3};

    for (int i = 0; i < NREQ; i++) begin
      t_op1[i] = 8'($urandom); t_op2[i] = 8'($urandom); t_op[i] = 3'($urandom_range(0, 3));
    end
    drive_ops();
    bus.req       = 4'hF;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;

    // Reset state, with all requests raised.
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    bus.req = '0;
    rst_n   = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Table vectors, one requester at a time.
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        t_op1[j] = 8'($urandom); t_op2[j] = 8'($urandom); t_op[j] = 3'($urandom);
      end
      t_op1[tbl[i].id] = tbl[i].a;
      t_op2[tbl[i].id] = tbl[i].b;
      t_op[tbl[i].id]  = tbl[i].op;
      run_op(4'(1) << tbl[i].id, 1'b0, tbl[i].stall, gid, r, z, e);
      chk("tbl_id", 32'(gid), 32'(tbl[i].id));
      chk("tbl_rsp", {r, z, e}, {tbl[i].res, tbl[i].zero, tbl[i].err});
    end

    // Round-robin order with every request held; last round drops requester 2.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        t_op1[j] = 8'($urandom); t_op2[j] = 8'($urandom); t_op[j] = 3'($urandom_range(0, 3));
      end
      run_op(ord_mask[i], 1'b1, 0, gid, r, z, e);
      chk("rr_order", 32'(gid), 32'(ord_id[i]));
    end
    bus.req = '0;
    tick();

    // Requester 3 withdraws just before its turn; requester 1 must win.
    t_op1[2] = 8'h21; t_op2[2] = 8'h01; t_op[2] = 3'd1;
    drive_ops();
    bus.req = 4'b0100;
    #1;
    chk("wd_gnt2", 32'(bus.gnt), 32'b0100);
    tick();
    bus.req = 4'b1010;
    chk("wd_exec_gnt", 32'(bus.gnt), 32'd0);
    tick();
    chk("wd_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result}, {1'b1, 2'd2, 8'h20});
    tick();
    chk("wd_resp_gnt", 32'(bus.gnt), 32'd0);
    bus.req       = 4'b0010;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    m_ptr = 3;
    run_op(4'b0010, 1'b0, 0, gid, r, z, e);
    chk("wd_winner", 32'(gid), 32'd1);

    // Reset during EXEC: everything clears and the pointer restarts at 0.
    t_op1[0] = 8'h44; t_op2[0] = 8'h11; t_op[0] = 3'd0;
    drive_ops();
    bus.req = 4'b0001;
    tick();
    chk("rst_exec_busy", 32'(bus.busy), 32'd1);
    bus.req = 4'hF;
    rst_n   = 1'b0;
    #1;
    chk_all_zero("rst_exec");
    tick();
    chk_all_zero("rst_hold");
    rst_n   = 1'b1;
    bus.req = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_no_rsp", {bus.rsp_valid, bus.busy}, 32'd0);
    end
    m_ptr = 0;
    run_op(4'hF, 1'b0, 0, gid, r, z, e);
    chk("rst_ptr0", 32'(gid), 32'd0);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 150; it++) begin
      for (int j = 0; j < NREQ; j++) begin
        t_op1[j] = 8'($urandom);
        t_op2[j] = ($urandom_range(0, 7) == 0) ? t_op1[j] : 8'($urandom);
        t_op[j]  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(4, 7))
                                               : 3'($urandom_range(0, 3));
      end
      run_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), gid, r, z, e);
    end
    bus.req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
